// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two L1 request channels and the data_mem port seen by
//   dmem_arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives acks,
//            rdata, busy and the data_mem controls)
//   master : environment side (L1 controllers plus data_mem)
// Signals:
//   req0/1, addr0/1, wdata0/1, load_ctrl0/1, store_ctrl0/1 : per-requester
//   ack0/1, rdata, busy                                     : completion
//   mem_address, mem_wdata, mem_load_control,
//   mem_store_control, mem_rdata                            : data_mem port
interface dmem_arbiter_if #(
    parameter int n = 32
);
    logic          req0;
    logic          req1;
    logic [n-3:0]  addr0;
    logic [n-3:0]  addr1;
    logic [31:0]   wdata0;
    logic [31:0]   wdata1;
    logic [2:0]    load_ctrl0;
    logic [2:0]    load_ctrl1;
    logic [1:0]    store_ctrl0;
    logic [1:0]    store_ctrl1;
    logic          ack0;
    logic          ack1;
    logic [31:0]   rdata;
    logic          busy;
    logic [n-3:0]  mem_address;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_load_control;
    logic [1:0]    mem_store_control;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1,
               load_ctrl0, load_ctrl1, store_ctrl0, store_ctrl1, mem_rdata,
        output ack0, ack1, rdata, busy,
               mem_address, mem_wdata, mem_load_control, mem_store_control
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1,
               load_ctrl0, load_ctrl1, store_ctrl0, store_ctrl1, mem_rdata,
        input  ack0, ack1, rdata, busy,
               mem_address, mem_wdata, mem_load_control, mem_store_control
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester round-robin arbiter and access sequencer for the shared
//   single-port data_mem. One request is latched, driven to the memory for
//   exactly one ACCESS cycle, the read data is registered and a one-cycle
//   ack is returned to the owner in DONE.
// Ports:
//   clk      : system clock, rising edge
//   n_reset  : synchronous active-low reset
//   bus      : dmem_arbiter_if.slave (requests, acks, rdata, busy, data_mem)
//
//   state  | meaning
//   IDLE   | waiting; arbitrate and latch a request
//   ACCESS | memory port driven with the latched access
//   DONE   | ack to owner, rdata held, last_grant updated
module dmem_arbiter #(
    parameter int n = 32
) (
    input  logic          clk,
    input  logic          n_reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    logic          owner;
    logic          last_grant;
    logic [n-3:0]  lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_load;
    logic [1:0]    lat_store;
    logic [2:0]    load_q;
    logic [1:0]    store_q;
    logic [31:0]   rdata_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          busy_q;

    logic          grant_any;
    logic          grant_id;
    logic [n-3:0]  sel_addr;
    logic [31:0]   sel_wdata;
    logic [2:0]    sel_load;
    logic [1:0]    sel_store;
    logic          load_valid;

    always_comb begin
        grant_any = bus.req0 | bus.req1;
        // On contention the requester that did not win last time gets it.
        if (bus.req0 && bus.req1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = bus.req1;
        end
        if (grant_id) begin
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
            sel_load  = bus.load_ctrl1;
            sel_store = bus.store_ctrl1;
        end else begin
            sel_addr  = bus.addr0;
            sel_wdata = bus.wdata0;
            sel_load  = bus.load_ctrl0;
            sel_store = bus.store_ctrl0;
        end
        load_valid = (lat_load >= 3'd1) && (lat_load <= 3'd5);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_load   <= '0;
            lat_store  <= '0;
            load_q     <= '0;
            store_q    <= '0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (grant_any) begin
                        owner     <= grant_id;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        lat_load  <= sel_load;
                        lat_store <= sel_store;
                        // Memory controls are registered so they are only
                        // live for the ACCESS cycle; a store masks the load.
                        store_q   <= sel_store;
                        load_q    <= (sel_store != 2'b00) ? 3'b000 : sel_load;
                        busy_q    <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    store_q <= 2'b00;
                    load_q  <= 3'b000;
                    if ((lat_store != 2'b00) || !load_valid) begin
                        rdata_q <= '0;
                    end else begin
                        rdata_q <= bus.mem_rdata;
                    end
                    ack0_q <= ~owner;
                    ack1_q <= owner;
                    state  <= DONE;
                end
                DONE: begin
                    ack0_q     <= 1'b0;
                    ack1_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The store strobe is gated by reset directly so a reset edge that
    // lands on ACCESS can never write the array.
    assign bus.mem_store_control = n_reset ? store_q : 2'b00;
    assign bus.mem_load_control  = load_q;
    assign bus.mem_address       = lat_addr;
    assign bus.mem_wdata         = lat_wdata;
    assign bus.rdata             = rdata_q;
    assign bus.ack0              = ack0_q;
    assign bus.ack1              = ack1_q;
    assign bus.busy              = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a small behavioural data_mem
//   (word array, asynchronous read, write on rising edge).
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    dmem_arbiter_if #(.n(32)) bus ();

    dmem_arbiter #(.n(32)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // data_mem model
    logic [31:0] mem [0:15] = '{default: 32'h0};
    logic [31:0] rd_word;

    always @(posedge clk) begin
        case (bus.mem_store_control)
            2'b01: mem[bus.mem_address[3:0]] <= bus.mem_wdata;
            2'b10: mem[bus.mem_address[3:0]][15:0] <= bus.mem_wdata[15:0];
            2'b11: mem[bus.mem_address[3:0]][7:0] <= bus.mem_wdata[7:0];
            default: ;
        endcase
    end

    always_comb begin
        rd_word = mem[bus.mem_address[3:0]];
        case (bus.mem_load_control)
            3'b001:  bus.mem_rdata = rd_word;
            3'b010:  bus.mem_rdata = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b011:  bus.mem_rdata = {16'h0, rd_word[15:0]};
            3'b100:  bus.mem_rdata = {{24{rd_word[1]}}, rd_word[7:0]};
            3'b101:  bus.mem_rdata = {24'h0, rd_word[7:0]};
            default: bus.mem_rdata = 32'h0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic drive(input bit id, input logic [29:0] a, input logic [31:0] wd,
                         input logic [2:0] ld, input logic [1:0] st);
        if (id) begin
            bus.req1 = 1'b1; bus.addr1 = a; bus.wdata1 = wd;
            bus.load_ctrl1 = ld; bus.store_ctrl1 = st;
        end else begin
            bus.req0 = 1'b1; bus.addr0 = a; bus.wdata0 = wd;
            bus.load_ctrl0 = ld; bus.store_ctrl0 = st;
        end
    endtask

    // Single uncontended access from IDLE; checks cycles T, T+1, T+2, T+3.
    task automatic run_req(input string tag, input bit id, input logic [29:0] a,
                           input logic [31:0] wd, input logic [2:0] ld,
                           input logic [1:0] st, input logic [31:0] exp_rd);
        drive(id, a, wd, ld, st);
        #1;
        check({tag, "_t_store"}, {30'h0, bus.mem_store_control}, 32'h0);
        check({tag, "_t_busy"}, {31'h0, bus.busy}, 32'h0);
        step();
        check({tag, "_t1_busy"}, {31'h0, bus.busy}, 32'h1);
        check({tag, "_t1_store"}, {30'h0, bus.mem_store_control}, {30'h0, st});
        check({tag, "_t1_load"}, {29'h0, bus.mem_load_control},
              (st != 2'b00) ? 32'h0 : {29'h0, ld});
        check({tag, "_t1_addr"}, {2'b00, bus.mem_address}, {2'b00, a});
        check({tag, "_t1_wdata"}, bus.mem_wdata, wd);
        check({tag, "_t1_ack"}, {30'h0, bus.ack1, bus.ack0}, 32'h0);
        step();
        check({tag, "_t2_ack"}, {30'h0, bus.ack1, bus.ack0}, id ? 32'h2 : 32'h1);
        check({tag, "_t2_rdata"}, bus.rdata, exp_rd);
        check({tag, "_t2_busy"}, {31'h0, bus.busy}, 32'h1);
        check({tag, "_t2_store"}, {30'h0, bus.mem_store_control}, 32'h0);
        clear_reqs();
        step();
        check({tag, "_t3_ack"}, {30'h0, bus.ack1, bus.ack0}, 32'h0);
        check({tag, "_t3_busy"}, {31'h0, bus.busy}, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, {30'h0, bus.ack1, bus.ack0}, 32'h0);
        check({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
        check({tag, "_rdata"}, bus.rdata, 32'h0);
        check({tag, "_addr"}, {2'b00, bus.mem_address}, 32'h0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_load"}, {29'h0, bus.mem_load_control}, 32'h0);
        check({tag, "_store"}, {30'h0, bus.mem_store_control}, 32'h0);
    endtask

    initial begin
        logic [12:0] exp_a0;
        logic [12:0] exp_a1;
        logic [12:0] exp_busy;

        clear_reqs();
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.load_ctrl0 = '0; bus.load_ctrl1 = '0;
        bus.store_ctrl0 = '0; bus.store_ctrl1 = '0;

        n_reset = 1'b0;
        step(); step(); step();
        n_reset = 1'b1;
        step();
        check_reset_outputs("reset");

        // SW then LW from requester 0
        run_req("sw0", 1'b0, 30'h5, 32'hDEADBEEF, 3'b000, 2'b01, 32'h0);
        check("sw0_mem5", mem[5], 32'hDEADBEEF);
        run_req("lw0", 1'b0, 30'h5, 32'h0, 3'b001, 2'b00, 32'hDEADBEEF);

        // Contention after reset: grants 0,1,0,1 with acks at T+2,5,8,11
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        drive(1'b0, 30'h5, 32'h0, 3'b001, 2'b00);
        drive(1'b1, 30'h0, 32'h0, 3'b001, 2'b00);
        exp_a0   = 13'b0000100000100;
        exp_a1   = 13'b0100000100000;
        exp_busy = 13'b0110110110110;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("rr_ack0_c%0d", k), {31'h0, bus.ack0}, {31'h0, exp_a0[k]});
            check($sformatf("rr_ack1_c%0d", k), {31'h0, bus.ack1}, {31'h0, exp_a1[k]});
            check($sformatf("rr_busy_c%0d", k), {31'h0, bus.busy}, {31'h0, exp_busy[k]});
            if (exp_a0[k]) check($sformatf("rr_rdata0_c%0d", k), bus.rdata, 32'hDEADBEEF);
            if (exp_a1[k]) check($sformatf("rr_rdata1_c%0d", k), bus.rdata, 32'h0);
            if (k == 11) clear_reqs();
        end

        // SH with a load also set: store wins, rdata 0
        run_req("sh1", 1'b1, 30'h7, 32'h12345678, 3'b001, 2'b10, 32'h0);
        check("sh1_mem7", mem[7], 32'h00005678);

        // Byte loads pass mem_rdata through unchanged
        run_req("sw_3", 1'b0, 30'h3, 32'h000080F0, 3'b000, 2'b01, 32'h0);
        run_req("lb1", 1'b1, 30'h3, 32'h0, 3'b100, 2'b00, 32'h000000F0);
        run_req("lbu1", 1'b1, 30'h3, 32'h0, 3'b101, 2'b00, 32'h000000F0);

        // Reset during ACCESS of an SW to addr 9
        drive(1'b0, 30'h9, 32'hCAFEF00D, 3'b000, 2'b01);
        step();
        check("rst_acc_store_pre", {30'h0, bus.mem_store_control}, 32'h1);
        n_reset = 1'b0;
        #1;
        check("rst_acc_store_gated", {30'h0, bus.mem_store_control}, 32'h0);
        step();
        check("rst_acc_mem9", mem[9], 32'h0);
        check_reset_outputs("rst_acc");
        clear_reqs();
        n_reset = 1'b1;
        step();
        check("rst_acc_noack", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        check("rst_acc_idle_busy", {31'h0, bus.busy}, 32'h0);

        // No-op request from requester 1
        run_req("nop1", 1'b1, 30'h2, 32'h0, 3'b000, 2'b00, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester round-robin arbiter and access sequencer for the shared single-port `data_mem`. It sits between the two L1 cache controllers and `data_mem`. It latches one request, drives the memory for exactly one access cycle, registers the read data and returns a one-cycle acknowledge. Only one requester owns the memory port at a time, and every store reaches the array in a single, well-defined cycle.

## Interface
Parameters:
- `n`, 32: architectural address width. Word address width is `n-2`.

Ports:
- `clk` input 1: system clock; all state updates on its rising edge.
- `n_reset` input 1: reset, synchronous, active-low.
- `req0`, `req1` input 1 each: access request from L1 0 / L1 1. Level; held until that requester's ack.
- `addr0`, `addr1` input n-2: word address per requester.
- `wdata0`, `wdata1` input 32: store data per requester.
- `load_ctrl0`, `load_ctrl1` input 3: `data_mem` load encoding (001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU, other = none).
- `store_ctrl0`, `store_ctrl1` input 2: `data_mem` store encoding (01 SW, 10 SH, 11 SB, 00 none).
- `ack0`, `ack1` output 1: one-cycle completion strobe to the owning requester.
- `rdata` output 32: registered read result, shared by both requesters, valid while the matching ack is high.
- `busy` output 1: high in states ACCESS and DONE.
- `mem_address` output n-2: to `data_mem` address.
- `mem_wdata` output 32: to `data_mem` dmem_wdata.
- `mem_load_control` output 3: to `data_mem` load_control.
- `mem_store_control` output 2: to `data_mem` store_control.
- `mem_rdata` input 32: from `data_mem` dmem_rdata (asynchronous read).

## Operation
- State machine with three states: IDLE → ACCESS → DONE → IDLE. There are no other transitions, except that reset forces IDLE from any state.
- IDLE:
  - If no request is high, stay in IDLE.
  - If exactly one request is high, grant that requester.
  - If both are high, grant the requester that is not `last_grant`.
  - On grant, latch the owner id and that requester's addr, wdata, load_ctrl and store_ctrl into internal registers, then go to ACCESS.
- ACCESS:
  - The memory outputs drive the latched values.
  - If the latched store_ctrl ≠ 00, `mem_load_control` is forced to 000 (store has precedence) and `rdata` is loaded with 0.
  - Otherwise `rdata` is loaded from `mem_rdata` at the end of the cycle.
  - Next state is DONE.
- DONE:
  - Assert ack of the owner only; `rdata` is held.
  - Set `last_grant` to the owner.
  - Next state is IDLE.
  - Requests are ignored in this state.
- Memory outputs in every state other than ACCESS:
  - `mem_store_control` = 00 and `mem_load_control` = 000.
  - `mem_address` and `mem_wdata` hold the latched values (no toggling).
- `mem_store_control` is gated combinationally by `n_reset`. No store reaches `data_mem` on a clock edge where `n_reset` = 0.
- A request with store_ctrl = 00 and load_ctrl = none is still sequenced and acknowledged, with `rdata` = 0.
- Each requester drives its inputs stably from raising req until it samples its ack. It deasserts req on the edge at which it samples ack, so the following IDLE cycle sees req low.

## Timing
- Reset values:
  - State = IDLE, `last_grant` = 1 (requester 0 wins the first contention).
  - `ack0` = `ack1` = 0, `busy` = 0, `rdata` = 0.
  - Latched address/wdata = 0, so `mem_address` = 0 and `mem_wdata` = 0.
  - `mem_load_control` = 000, `mem_store_control` = 00.
- Latency: a req seen high in IDLE cycle T gives ACCESS at T+1 and ack at T+2. The store is written into `data_mem` at the rising edge ending T+1.
- Throughput: one access per 3 cycles under continuous requests. Contending requesters alternate strictly: 0, 1, 0, 1 …
- A req arriving while `busy` waits. It is considered in the next IDLE cycle with round-robin priority.
- Reset mid-operation (ACCESS or DONE): next state is IDLE, no ack is issued, the pending store is dropped, and `rdata` = 0.
- `ack0` and `ack1` are never high together and never high for more than one consecutive cycle.

## Test plan
- Reset, then `req0` alone with SW, addr 0x05, wdata 0xDEADBEEF → `mem_store_control` = 01 only in cycle T+1, `ack0` at T+2. A following LW of addr 0x05 from `req0` → `rdata` = 0xDEADBEEF with `ack0`.
- `req0` and `req1` raised in the same cycle after reset, both holding → grant order 0, 1, 0, 1. Acks in cycles T+2, T+5, T+8, T+11.
- Store 0x000080F0 at addr 3, then LB and LBU from `req1` → `rdata` = 0xFFFFFFF0? No: `data_mem` sign-extends from bit 1, giving `rdata` = 0x000000F0 for both. Check that the arbiter passes `mem_rdata` through unchanged.
- `store_ctrl1` = 10 with `load_ctrl1` = 001, wdata 0x12345678, addr 7 → `mem_load_control` = 000, `rdata` = 0, and memory word 7 = 0x00005678.
- `n_reset` pulled low during ACCESS of an SW to addr 9 → memory word 9 unchanged, no ack, state IDLE, all outputs at reset values.
- No-op request (store 00, load 000) from `req1` → `ack1` at T+2 with `rdata` = 0; `busy` high in T+1 and T+2 only.
